// File: rtl/palette_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palette_sched_pkg
// Description : Shared types and constants for the palette lookup scheduler.
//               Provides the LUT index/colour widths, the host FSM state
//               encoding, the stage-1 owner tags and the blanking colour.
// Revision    : 1.0 - initial release
// ============================================================================
package palette_sched_pkg;

    localparam int IDX_W = 7;   // {hue[3:0], lum[3:1]}
    localparam int RGB_W = 24;
    localparam int HUE_W = 4;
    localparam int LUM_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ISSUED = 2'd2,
        ACK    = 2'd3
    } host_state_e;

    // Who owns the LUT index held in stage 1.
    localparam logic OWN_VIDEO = 1'b0;
    localparam logic OWN_HOST  = 1'b1;

    localparam logic [RGB_W-1:0] BLACK_RGB = 24'h000000;

endpackage : palette_sched_pkg
`default_nettype wire

// File: rtl/palette_DB.sv
`default_nettype none
// ============================================================================
// Module      : palette_DB
// Description : Combinational NTSC palette LUT. 16 hues x 8 luminance steps
//               mapped to 24-bit RGB.
// Ports       : hue_i        - colour hue (4 bits)
//               lum_i        - luminance step, i.e. lum[3:1] (3 bits)
//               rgb_24bpp_o  - {R, G, B} colour
// Revision    : 1.0 - initial release
// ============================================================================
module palette_DB
    import palette_sched_pkg::*;
(
    input  logic [HUE_W-1:0] hue_i,
    input  logic [LUM_W-2:0] lum_i,
    output logic [RGB_W-1:0] rgb_24bpp_o
);

    // One row per hue, eight luminance steps per row.
    localparam logic [RGB_W-1:0] PALETTE [128] = '{
        24'h000000, 24'h404040, 24'h6C6C6C, 24'h909090, 24'hB0B0B0, 24'hC8C8C8, 24'hDCDCDC, 24'hECECEC,
        24'h444400, 24'h646410, 24'h848424, 24'hA0A034, 24'hB8B840, 24'hD0D050, 24'hE8E85C, 24'hFCFC68,
        24'h702800, 24'h844414, 24'h985C28, 24'hAC783C, 24'hBC8C4C, 24'hCCA05C, 24'hDCB468, 24'hECC878,
        24'h841800, 24'h983418, 24'hAC5030, 24'hC06848, 24'hD0805C, 24'hE09470, 24'hECA880, 24'hFCBC94,
        24'h880000, 24'h9C2020, 24'hB03C3C, 24'hC05858, 24'hD07070, 24'hE08888, 24'hECA0A0, 24'hFCB4B4,
        24'h78005C, 24'h8C2074, 24'hA03C88, 24'hB0589C, 24'hC070B0, 24'hD084C0, 24'hDC9CD0, 24'hECB0E0,
        24'h480078, 24'h602090, 24'h783CA4, 24'h8C58B8, 24'hA070CC, 24'hB484DC, 24'hC49CEC, 24'hD4B0FC,
        24'h140084, 24'h302098, 24'h4C3CAC, 24'h6858C0, 24'h7C70D0, 24'h9488E0, 24'hA8A0EC, 24'hBCB4FC,
        24'h000088, 24'h1C209C, 24'h3840B0, 24'h505CC0, 24'h6874D0, 24'h7C8CE0, 24'h90A4EC, 24'hA4B8FC,
        24'h00187C, 24'h1C3890, 24'h3854A8, 24'h5070BC, 24'h6888CC, 24'h7C9CDC, 24'h90B4EC, 24'hA4C8FC,
        24'h002C5C, 24'h1C4C78, 24'h386890, 24'h5084AC, 24'h689CC0, 24'h7CB4D4, 24'h90CCE8, 24'hA4E0FC,
        24'h003C2C, 24'h1C5C48, 24'h387C64, 24'h509C80, 24'h68B494, 24'h7CD0AC, 24'h90E4C0, 24'hA4FCD4,
        24'h003C00, 24'h205C20, 24'h407C40, 24'h5C9C5C, 24'h74B474, 24'h8CD08C, 24'hA4E4A4, 24'hB8FCB8,
        24'h143800, 24'h345C1C, 24'h507C38, 24'h6C9850, 24'h84B468, 24'h9CCC7C, 24'hB4E490, 24'hC8FCA4,
        24'h2C3000, 24'h4C501C, 24'h687034, 24'h848C4C, 24'h9CA864, 24'hB4C078, 24'hCCD488, 24'hE0EC9C,
        24'h442800, 24'h644818, 24'h846830, 24'hA08444, 24'hB89C58, 24'hD0B46C, 24'hE8CC7C, 24'hFCE08C
    };

    assign rgb_24bpp_o = PALETTE[{hue_i, lum_i}];

endmodule : palette_DB
`default_nettype wire

// File: rtl/palette_lookup_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : palette_lookup_scheduler
// Description : Time-shares one combinational palette LUT between the video
//               pixel stream (strict priority, never stalled) and a host
//               readback port that only uses free slots (idle or blanking).
//               Two-stage pipeline: stage 1 registers the chosen index, stage 2
//               registers the LUT result and applies blanking.
// Optional    : PALETTE_BW_SWITCH_EN - adds bw_mode_i; when high the video
//               hue is forced to 0 (B/W console switch). Host path unaffected.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               pix_valid_i/pix_blank_i/pix_hue_i/pix_lum_i - pixel slot in
//               rgb_out_o/rgb_valid_o - registered pixel colour, 2-cycle latency
//               host_req_i/host_idx_i - host lookup request (level) and index
//               host_ack_o/host_err_o/host_rgb_o - completion pulse, timeout
//               flag, lookup result (held until next ack)
// Revision    : 1.0 - initial release
// ============================================================================
module palette_lookup_scheduler
    import palette_sched_pkg::*;
#(
    parameter int HOST_TIMEOUT = 1024,
    parameter int TIMEOUT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid_i,
    input  logic             pix_blank_i,
    input  logic [HUE_W-1:0] pix_hue_i,
    input  logic [LUM_W-1:0] pix_lum_i,
`ifdef PALETTE_BW_SWITCH_EN
    input  logic             bw_mode_i,
`endif
    output logic [RGB_W-1:0] rgb_out_o,
    output logic             rgb_valid_o,
    input  logic             host_req_i,
    input  logic [IDX_W-1:0] host_idx_i,
    output logic             host_ack_o,
    output logic             host_err_o,
    output logic [RGB_W-1:0] host_rgb_o
);

    // Last wait-counter value before timeout; only meaningful when enabled.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(HOST_TIMEOUT - 1);
    localparam bit                   TO_EN   = (HOST_TIMEOUT != 0);

    // ------------------------------------------------------------------
    // Stage 1: slot arbitration and index select
    // ------------------------------------------------------------------
    logic             slot_free;
    logic             video_sel;
    logic             host_grant;
    logic [HUE_W-1:0] vid_hue;
    logic [IDX_W-1:0] idx_d;
    logic             own_d;
    logic             unused_lum0;

    host_state_e      state_q;
    logic [TIMEOUT_W-1:0] wait_cnt_q;

    logic [IDX_W-1:0] s1_idx_q;
    logic             s1_own_q;
    logic             s1_valid_q;
    logic             s1_blank_q;

    logic [RGB_W-1:0] lut_rgb;
    logic [RGB_W-1:0] rgb_out_q;
    logic             rgb_valid_q;
    logic             host_ack_q;
    logic             host_err_q;
    logic [RGB_W-1:0] host_rgb_q;

    // Luminance LSB does not select a palette entry.
    assign unused_lum0 = pix_lum_i[0];

`ifdef PALETTE_BW_SWITCH_EN
    assign vid_hue = bw_mode_i ? '0 : pix_hue_i;
`else
    assign vid_hue = pix_hue_i;
`endif

    assign slot_free  = !pix_valid_i || pix_blank_i;
    assign video_sel  = !slot_free;
    assign host_grant = slot_free && (state_q == WAIT);

    always_comb begin
        idx_d = host_idx_i;
        own_d = OWN_VIDEO;
        if (video_sel) begin
            idx_d = {vid_hue, pix_lum_i[LUM_W-1:1]};
        end else if (host_grant) begin
            own_d = OWN_HOST;
        end
    end

    // ------------------------------------------------------------------
    // Shared LUT, driven from the stage-1 registered index
    // ------------------------------------------------------------------
    palette_DB u_palette_db (
        .hue_i       (s1_idx_q[IDX_W-1 -: HUE_W]),
        .lum_i       (s1_idx_q[LUM_W-2:0]),
        .rgb_24bpp_o (lut_rgb)
    );

    // ------------------------------------------------------------------
    // Video pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_idx_q    <= '0;
            s1_own_q    <= OWN_VIDEO;
            s1_valid_q  <= 1'b0;
            s1_blank_q  <= 1'b0;
            rgb_out_q   <= BLACK_RGB;
            rgb_valid_q <= 1'b0;
        end else begin
            s1_idx_q    <= idx_d;
            s1_own_q    <= own_d;
            s1_valid_q  <= pix_valid_i;
            s1_blank_q  <= pix_blank_i;
            rgb_valid_q <= s1_valid_q;
            // Without a valid pixel the previous colour is held, which also
            // keeps host lookups from leaking onto the video output.
            if (s1_valid_q) begin
                if (s1_blank_q) begin
                    rgb_out_q <= BLACK_RGB;
                end else if (s1_own_q == OWN_VIDEO) begin
                    rgb_out_q <= lut_rgb;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Host request FSM with registered completion outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
            host_rgb_q <= BLACK_RGB;
        end else begin
            host_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host_req_i) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT: begin
                    // A free slot beats both an abort and a timeout.
                    if (slot_free) begin
                        state_q <= ISSUED;
                    end else if (!host_req_i) begin
                        state_q <= IDLE;
                    end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
                        state_q    <= ACK;
                        host_ack_q <= 1'b1;
                        host_err_q <= 1'b1;
                        host_rgb_q <= BLACK_RGB;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ISSUED: begin
                    // The LUT is presenting the granted host index this cycle.
                    state_q    <= ACK;
                    host_ack_q <= 1'b1;
                    host_err_q <= 1'b0;
                    host_rgb_q <= lut_rgb;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rgb_out_o   = rgb_out_q;
    assign rgb_valid_o = rgb_valid_q;
    assign host_ack_o  = host_ack_q;
    assign host_err_o  = host_err_q;
    assign host_rgb_o  = host_rgb_q;

endmodule : palette_lookup_scheduler
`default_nettype wire
